exe_alu_branch_unit: RTL and testbench
======================================

// Module: exe_alu_branch_unit
// PURPOSE
//  Execute-stage datapath core: combinational 32-bit MIPS-style integer ALU with internal HI/LO
//  registers for multiply/divide and moves, plus a branch-condition comparator that decodes the
//  instruction word. Sits inside the EXE stage. Feeds result/broadcast, and taken drives the alt-PC/flush request.
// PARAMETERS
//  none (32-bit datapath, 6-bit ALU control, 5-bit shift amount fixed)
// PORTS
//  CLK          in   1   clock, rising edge
//  RESET        in   1   asynchronous, active-low reset
//  EN           in   1   instruction valid; gates HI/LO writes
//  A            in   32  operand A (rs)
//  B            in   32  operand B (rt or immediate)
//  ALU_control  in   6   operation code (table below)
//  shiftAmount  in   5   shamt for constant shifts
//  Instr_input  in   32  instruction word for branch decode
//  Jump         in   1   unconditional jump/jr/jal indicator
//  aluResult    out  32  combinational result
//  HI_OUT       out  32  combinational next-HI value
//  LO_OUT       out  32  combinational next-LO value
//  taken        out  1   branch/jump taken (combinational)
//  overflow     out  1   signed overflow (see CONFIGURATION)
// BEHAVIOUR
//  - Codes (hex): 00 A+B; 01 A-B; 02 AND; 03 OR; 04 XOR; 05 NOR; 06 SLT signed ->{31'b0,A<B};
//    07 SLTU; 08 SLL B<<shamt; 09 SRL; 0A SRA; 0B SLLV B<<A[4:0]; 0C SRLV; 0D SRAV; 0E LUI B<<16;
//    0F MULT {HI,LO}=A*B signed; 10 MULTU; 11 DIV LO=A/B,HI=A%B signed (trunc toward 0);
//    12 DIVU; 13 MFHI res=HI; 14 MFLO res=LO; 15 MTHI HI=A; 16 MTLO LO=A; 17 pass B;
//    18 ADD signed; 19 SUB signed. Undefined codes: aluResult=0, HI/LO unchanged.
//  - Arithmetic wraps mod 2^32; codes 0F-12,15,16 give aluResult=0.
//  - DIV/DIVU with B==0: HI/LO unchanged. DIV 0x80000000/-1: LO=0x80000000, HI=0.
//  - HI_OUT/LO_OUT = value HI/LO will take; equal current HI/LO for non-writing codes.
//  - HI/LO registers load HI_OUT/LO_OUT on rising CLK when EN=1; MFHI/MFLO see them next cycle.
//  - Reset (RESET=0, async): HI=LO=0 immediately; combinational outputs follow inputs.
//  - Branch decode, op=Instr_input[31:26], rt=[20:16], signed compares:
//    Jump=1 -> taken=1 regardless of op; 04 BEQ A==B; 05 BNE A!=B; 06 BLEZ A<=0; 07 BGTZ A>0;
//    01 REGIMM: rt 00/10 BLTZ(AL) A<0; rt 01/11 BGEZ(AL) A>=0; other rt -> 0; any other op -> 0.
//  - Zero latency for aluResult/taken; no handshake; simultaneous EN and reset: reset wins.
// CONFIGURATION
//  ALU_OVF_TRAP_EN defined: overflow=1 when code 18/19 signed result overflows, else 0;
//    aluResult still holds the wrapped sum/difference.
//  Not defined: overflow tied 0; codes 18/19 identical to 00/01.
// TESTING
//  - A=0x7FFFFFFF,B=1,ctl=00 -> res 0x80000000; ctl=18 -> overflow=1 only with ALU_OVF_TRAP_EN.
//  - B=0x80000000,shamt=4: SRL -> 0x08000000, SRA -> 0xF8000000; SLT A=-1,B=1 -> 1, SLTU -> 0.
//  - MULT A=-2,B=3,EN=1, clock; then MFHI -> 0xFFFFFFFF, MFLO -> 0xFFFFFFFA; DIV 7/-2 -> LO=-3,HI=1.
//  - DIV B=0 after HI/LO loaded -> HI/LO keep prior values; EN=0 MTHI -> HI unchanged after edge.
//  - Instr op=04, A=B=5 -> taken=1; op=01 rt=01 A=-1 -> 0; op=07 A=0 -> 0; Jump=1 any op -> 1.
//  - Drop RESET mid-cycle after HI load -> HI_OUT/LO_OUT reflect 0 before any clock edge.

Source files
------------

// File: rtl/exe_alu_branch_unit_if.sv
// Operand/control bundle and result bundle of the EXE-stage ALU/branch unit.
// The master drives the instruction and operands; the slave (the unit) returns results.
interface exe_alu_branch_unit_if;
    logic        EN;
    logic [31:0] A;
    logic [31:0] B;
    logic [5:0]  ALU_control;
    logic [4:0]  shiftAmount;
    logic [31:0] Instr_input;
    logic        Jump;
    logic [31:0] aluResult;
    logic [31:0] HI_OUT;
    logic [31:0] LO_OUT;
    logic        taken;
    logic        overflow;

    modport master (
        output EN, A, B, ALU_control, shiftAmount, Instr_input, Jump,
        input  aluResult, HI_OUT, LO_OUT, taken, overflow
    );

    modport slave (
        input  EN, A, B, ALU_control, shiftAmount, Instr_input, Jump,
        output aluResult, HI_OUT, LO_OUT, taken, overflow
    );
endinterface

// File: rtl/exe_alu_branch_unit.sv
// Combinational MIPS-style ALU with HI/LO registers and a branch-condition comparator.
// Optional macro ALU_OVF_TRAP_EN enables signed-overflow reporting for ADD/SUB (codes 18/19).
module exe_alu_branch_unit (
    input logic                  CLK,
    input logic                  RESET,
    exe_alu_branch_unit_if.slave bus
);

    localparam logic [5:0] OP_ADDU  = 6'h00;
    localparam logic [5:0] OP_SUBU  = 6'h01;
    localparam logic [5:0] OP_AND   = 6'h02;
    localparam logic [5:0] OP_OR    = 6'h03;
    localparam logic [5:0] OP_XOR   = 6'h04;
    localparam logic [5:0] OP_NOR   = 6'h05;
    localparam logic [5:0] OP_SLT   = 6'h06;
    localparam logic [5:0] OP_SLTU  = 6'h07;
    localparam logic [5:0] OP_SLL   = 6'h08;
    localparam logic [5:0] OP_SRL   = 6'h09;
    localparam logic [5:0] OP_SRA   = 6'h0A;
    localparam logic [5:0] OP_SLLV  = 6'h0B;
    localparam logic [5:0] OP_SRLV  = 6'h0C;
    localparam logic [5:0] OP_SRAV  = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0E;
    localparam logic [5:0] OP_MULT  = 6'h0F;
    localparam logic [5:0] OP_MULTU = 6'h10;
    localparam logic [5:0] OP_DIV   = 6'h11;
    localparam logic [5:0] OP_DIVU  = 6'h12;
    localparam logic [5:0] OP_MFHI  = 6'h13;
    localparam logic [5:0] OP_MFLO  = 6'h14;
    localparam logic [5:0] OP_MTHI  = 6'h15;
    localparam logic [5:0] OP_MTLO  = 6'h16;
    localparam logic [5:0] OP_PASSB = 6'h17;
    localparam logic [5:0] OP_ADD   = 6'h18;
    localparam logic [5:0] OP_SUB   = 6'h19;

    localparam logic [5:0] BR_REGIMM = 6'h01;
    localparam logic [5:0] BR_BEQ    = 6'h04;
    localparam logic [5:0] BR_BNE    = 6'h05;
    localparam logic [5:0] BR_BLEZ   = 6'h06;
    localparam logic [5:0] BR_BGTZ   = 6'h07;

    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] hi_next;
    logic [31:0] lo_next;
    logic [31:0] result;
    logic        ovf;
    logic        br_taken;

    logic [31:0] sum;
    logic [31:0] diff;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic        div_zero;
    logic        div_ovf;

    logic [5:0]  br_op;
    logic [4:0]  br_rt;
    logic        a_neg;
    logic        a_zero;
    logic        unused_instr;

    assign sum      = bus.A + bus.B;
    assign diff     = bus.A - bus.B;
    assign prod_s   = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    assign prod_u   = {32'd0, bus.A} * {32'd0, bus.B};
    assign div_zero = (bus.B == 32'd0);
    assign div_ovf  = (bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF);

    // Dividers are fenced off for the two cases the ALU defines explicitly,
    // so the operators never see a zero divisor or the INT_MIN/-1 overflow.
    always_comb begin
        quot_s = 32'd0;
        rem_s  = 32'd0;
        quot_u = 32'd0;
        rem_u  = 32'd0;
        if (!div_zero) begin
            quot_u = bus.A / bus.B;
            rem_u  = bus.A % bus.B;
            if (div_ovf) begin
                quot_s = 32'h8000_0000;
                rem_s  = 32'd0;
            end else begin
                quot_s = $signed(bus.A) / $signed(bus.B);
                rem_s  = $signed(bus.A) % $signed(bus.B);
            end
        end
    end

    always_comb begin
        result  = 32'd0;
        hi_next = hi_q;
        lo_next = lo_q;
        case (bus.ALU_control)
            OP_ADDU:  result = sum;
            OP_SUBU:  result = diff;
            OP_AND:   result = bus.A & bus.B;
            OP_OR:    result = bus.A | bus.B;
            OP_XOR:   result = bus.A ^ bus.B;
            OP_NOR:   result = ~(bus.A | bus.B);
            OP_SLT:   result = {31'd0, $signed(bus.A) < $signed(bus.B)};
            OP_SLTU:  result = {31'd0, bus.A < bus.B};
            OP_SLL:   result = bus.B << bus.shiftAmount;
            OP_SRL:   result = bus.B >> bus.shiftAmount;
            OP_SRA:   result = $signed(bus.B) >>> bus.shiftAmount;
            OP_SLLV:  result = bus.B << bus.A[4:0];
            OP_SRLV:  result = bus.B >> bus.A[4:0];
            OP_SRAV:  result = $signed(bus.B) >>> bus.A[4:0];
            OP_LUI:   result = bus.B << 16;
            OP_MULT: begin
                hi_next = prod_s[63:32];
                lo_next = prod_s[31:0];
            end
            OP_MULTU: begin
                hi_next = prod_u[63:32];
                lo_next = prod_u[31:0];
            end
            OP_DIV: begin
                if (!div_zero) begin
                    hi_next = rem_s;
                    lo_next = quot_s;
                end
            end
            OP_DIVU: begin
                if (!div_zero) begin
                    hi_next = rem_u;
                    lo_next = quot_u;
                end
            end
            OP_MFHI:  result  = hi_q;
            OP_MFLO:  result  = lo_q;
            OP_MTHI:  hi_next = bus.A;
            OP_MTLO:  lo_next = bus.A;
            OP_PASSB: result  = bus.B;
            OP_ADD:   result  = sum;
            OP_SUB:   result  = diff;
            default:  result  = 32'd0;
        endcase
    end

`ifdef ALU_OVF_TRAP_EN
    // Signed overflow: operands agree in sign (add) or differ (sub) and the result sign flips.
    always_comb begin
        ovf = 1'b0;
        if (bus.ALU_control == OP_ADD)
            ovf = (bus.A[31] == bus.B[31]) && (sum[31] != bus.A[31]);
        else if (bus.ALU_control == OP_SUB)
            ovf = (bus.A[31] != bus.B[31]) && (diff[31] != bus.A[31]);
    end
`else
    assign ovf = 1'b0;
`endif

    assign br_op        = bus.Instr_input[31:26];
    assign br_rt        = bus.Instr_input[20:16];
    assign a_neg        = bus.A[31];
    assign a_zero       = (bus.A == 32'd0);
    assign unused_instr = ^{bus.Instr_input[25:21], bus.Instr_input[15:0]};

    // REGIMM link variants (BLTZAL/BGEZAL) share the condition of their plain forms.
    always_comb begin
        br_taken = 1'b0;
        if (bus.Jump) begin
            br_taken = 1'b1;
        end else begin
            case (br_op)
                BR_BEQ:  br_taken = (bus.A == bus.B);
                BR_BNE:  br_taken = (bus.A != bus.B);
                BR_BLEZ: br_taken = a_neg || a_zero;
                BR_BGTZ: br_taken = !a_neg && !a_zero;
                BR_REGIMM: begin
                    case (br_rt)
                        5'h00, 5'h10: br_taken = a_neg;
                        5'h01, 5'h11: br_taken = !a_neg;
                        default:      br_taken = 1'b0;
                    endcase
                end
                default: br_taken = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (bus.EN) begin
            hi_q <= hi_next;
            lo_q <= lo_next;
        end
    end

    assign bus.aluResult = result;
    assign bus.HI_OUT    = hi_next;
    assign bus.LO_OUT    = lo_next;
    assign bus.taken     = br_taken;
    assign bus.overflow  = ovf;

endmodule

// File: tb/tb_exe_alu_branch_unit.sv
// Scoreboard bench for exe_alu_branch_unit: directed corner cases then random traffic,
// each compared against a behavioural model of the ALU, HI/LO and branch rules.
module tb_exe_alu_branch_unit;

    logic CLK;
    logic RESET;

    exe_alu_branch_unit_if bus ();

    exe_alu_branch_unit dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct {
        int          id;
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        tk;
        logic        ovf;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          passes = 0;
    int          item_id = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input int id, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected)
            passes++;
        else
            $display("[TB] FAIL %s item %0d: got %h expected %h", name, id, actual, expected);
    endtask

    // Reference model: spec rules expressed with integer arithmetic on the current HI/LO.
    task automatic refModel(input logic [31:0] a, input logic [31:0] b, input logic [5:0] ctl,
                            input logic [4:0] sh, input logic [31:0] instr, input logic jmp,
                            output exp_t e);
        longint      ps;
        logic [63:0] pv;
        longint      wide;
        logic [31:0] ones;
        logic [4:0]  va;
        logic [5:0]  op;
        logic [4:0]  rt;
        ones  = 32'hFFFF_FFFF;
        va    = a[4:0];
        e.res = 32'd0;
        e.hi  = model_hi;
        e.lo  = model_lo;
        e.ovf = 1'b0;
        case (ctl)
            6'h00, 6'h18: e.res = a + b;
            6'h01, 6'h19: e.res = a - b;
            6'h02: e.res = a & b;
            6'h03: e.res = a | b;
            6'h04: e.res = a ^ b;
            6'h05: e.res = ~(a | b);
            6'h06: e.res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            6'h07: e.res = (a < b) ? 32'd1 : 32'd0;
            6'h08: e.res = b << sh;
            6'h09: e.res = b >> sh;
            6'h0A: e.res = (b >> sh) | (b[31] ? ~(ones >> sh) : 32'd0);
            6'h0B: e.res = b << va;
            6'h0C: e.res = b >> va;
            6'h0D: e.res = (b >> va) | (b[31] ? ~(ones >> va) : 32'd0);
            6'h0E: e.res = {b[15:0], 16'h0000};
            6'h0F: begin
                ps   = longint'(int'(a)) * longint'(int'(b));
                pv   = ps;
                e.hi = pv[63:32];
                e.lo = pv[31:0];
            end
            6'h10: begin
                pv   = {32'd0, a} * {32'd0, b};
                e.hi = pv[63:32];
                e.lo = pv[31:0];
            end
            6'h11: begin
                if (b != 32'd0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        e.lo = 32'h8000_0000;
                        e.hi = 32'd0;
                    end else begin
                        e.lo = int'(a) / int'(b);
                        e.hi = int'(a) % int'(b);
                    end
                end
            end
            6'h12: begin
                if (b != 32'd0) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
            6'h13: e.res = model_hi;
            6'h14: e.res = model_lo;
            6'h15: e.hi  = a;
            6'h16: e.lo  = a;
            6'h17: e.res = b;
            default: e.res = 32'd0;
        endcase
`ifdef ALU_OVF_TRAP_EN
        if (ctl == 6'h18 || ctl == 6'h19) begin
            if (ctl == 6'h18) wide = longint'(int'(a)) + longint'(int'(b));
            else              wide = longint'(int'(a)) - longint'(int'(b));
            e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
        end
`else
        wide = 0;
`endif
        op   = instr[31:26];
        rt   = instr[20:16];
        e.tk = 1'b0;
        if (jmp) e.tk = 1'b1;
        else if (op == 6'h04) e.tk = (a == b);
        else if (op == 6'h05) e.tk = (a != b);
        else if (op == 6'h06) e.tk = (int'(a) <= 0);
        else if (op == 6'h07) e.tk = (int'(a) > 0);
        else if (op == 6'h01 && (rt == 5'h00 || rt == 5'h10)) e.tk = (int'(a) < 0);
        else if (op == 6'h01 && (rt == 5'h01 || rt == 5'h11)) e.tk = (int'(a) >= 0);
    endtask

    // Drive one instruction, queue its expectation, and advance the model's HI/LO
    // to what the registers will hold after the coming edge.
    task automatic applyStimulus(input logic en, input logic [31:0] a, input logic [31:0] b,
                                 input logic [5:0] ctl, input logic [4:0] sh,
                                 input logic [31:0] instr, input logic jmp);
        exp_t e;
        bus.EN          = en;
        bus.A           = a;
        bus.B           = b;
        bus.ALU_control = ctl;
        bus.shiftAmount = sh;
        bus.Instr_input = instr;
        bus.Jump        = jmp;
        refModel(a, b, ctl, sh, instr, jmp, e);
        e.id = item_id++;
        sb_q.push_back(e);
        if (en && RESET) begin
            model_hi = e.hi;
            model_lo = e.lo;
        end
    endtask

    task automatic issue(input logic en, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] ctl, input logic [4:0] sh,
                         input logic [31:0] instr, input logic jmp);
        @(posedge CLK);
        #1;
        applyStimulus(en, a, b, ctl, sh, instr, jmp);
    endtask

    function automatic logic [31:0] mkInstr(input logic [5:0] op, input logic [4:0] rt);
        return {op, 5'd3, rt, 16'h1234};
    endfunction

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge CLK) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput("aluResult", e.id, bus.aluResult, e.res);
            checkOutput("HI_OUT", e.id, bus.HI_OUT, e.hi);
            checkOutput("LO_OUT", e.id, bus.LO_OUT, e.lo);
            checkOutput("taken", e.id, {31'd0, bus.taken}, {31'd0, e.tk});
            checkOutput("overflow", e.id, {31'd0, bus.overflow}, {31'd0, e.ovf});
        end
    end

    initial begin
        logic [5:0]  rop;
        logic [5:0]  ops[7];
        ops = '{6'h00, 6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h02};

        RESET = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 6'h13, 5'd0, 32'd0, 1'b0);
        @(negedge CLK);
        #2 RESET = 1'b1;

        issue(1'b0, 32'h7FFF_FFFF, 32'd1, 6'h00, 5'd0, 32'd0, 1'b0);
        issue(1'b0, 32'h7FFF_FFFF, 32'd1, 6'h18, 5'd0, 32'd0, 1'b0);
        issue(1'b0, 32'h8000_0000, 32'd1, 6'h19, 5'd0, 32'd0, 1'b0);
        issue(1'b0, 32'd0, 32'h8000_0000, 6'h09, 5'd4, 32'd0, 1'b0);
        issue(1'b0, 32'd0, 32'h8000_0000, 6'h0A, 5'd4, 32'd0, 1'b0);
        issue(1'b0, 32'hFFFF_FFFF, 32'd1, 6'h06, 5'd0, 32'd0, 1'b0);
        issue(1'b0, 32'hFFFF_FFFF, 32'd1, 6'h07, 5'd0, 32'd0, 1'b0);
        issue(1'b1, 32'hFFFF_FFFE, 32'd3, 6'h0F, 5'd0, 32'd0, 1'b0);
        issue(1'b0, 32'd0, 32'd0, 6'h13, 5'd0, 32'd0, 1'b0);
        issue(1'b0, 32'd0, 32'd0, 6'h14, 5'd0, 32'd0, 1'b0);
        issue(1'b1, 32'd7, 32'hFFFF_FFFE, 6'h11, 5'd0, 32'd0, 1'b0);
        issue(1'b0, 32'd0, 32'd0, 6'h14, 5'd0, 32'd0, 1'b0);
        issue(1'b1, 32'd9, 32'd0, 6'h11, 5'd0, 32'd0, 1'b0);
        issue(1'b1, 32'd9, 32'd0, 6'h12, 5'd0, 32'd0, 1'b0);
        issue(1'b0, 32'd0, 32'd0, 6'h13, 5'd0, 32'd0, 1'b0);
        issue(1'b0, 32'h1234_5678, 32'd0, 6'h15, 5'd0, 32'd0, 1'b0);
        issue(1'b0, 32'd0, 32'd0, 6'h13, 5'd0, 32'd0, 1'b0);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 6'h11, 5'd0, 32'd0, 1'b0);
        issue(1'b0, 32'd0, 32'd0, 6'h13, 5'd0, 32'd0, 1'b0);
        issue(1'b0, 32'd0, 32'h0000_ABCD, 6'h0E, 5'd0, 32'd0, 1'b0);
        issue(1'b0, 32'd0, 32'd0, 6'h1F, 5'd0, 32'd0, 1'b0);
        issue(1'b0, 32'd5, 32'd5, 6'h00, 5'd0, mkInstr(6'h04, 5'd0), 1'b0);
        issue(1'b0, 32'hFFFF_FFFF, 32'd0, 6'h00, 5'd0, mkInstr(6'h01, 5'h01), 1'b0);
        issue(1'b0, 32'hFFFF_FFFF, 32'd0, 6'h00, 5'd0, mkInstr(6'h01, 5'h10), 1'b0);
        issue(1'b0, 32'd0, 32'd0, 6'h00, 5'd0, mkInstr(6'h07, 5'd0), 1'b0);
        issue(1'b0, 32'd0, 32'd0, 6'h00, 5'd0, mkInstr(6'h06, 5'd0), 1'b0);
        issue(1'b0, 32'd0, 32'd1, 6'h00, 5'd0, mkInstr(6'h01, 5'h02), 1'b0);
        issue(1'b0, 32'd1, 32'd2, 6'h00, 5'd0, mkInstr(6'h3F, 5'd0), 1'b1);

        issue(1'b1, 32'hCAFE_F00D, 32'd0, 6'h15, 5'd0, 32'd0, 1'b0);
        issue(1'b1, 32'h0BAD_BEEF, 32'd0, 6'h16, 5'd0, 32'd0, 1'b0);
        @(posedge CLK);
        #2;
        RESET    = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        applyStimulus(1'b1, 32'd0, 32'd0, 6'h13, 5'd0, 32'd0, 1'b0);
        @(negedge CLK);
        #2 RESET = 1'b1;
        issue(1'b0, 32'd0, 32'd0, 6'h14, 5'd0, 32'd0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            rop = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 3) == 0) rop = 6'($urandom_range(0, 63));
            issue(1'($urandom_range(0, 1)), randOperand(), randOperand(),
                  6'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  mkInstr(rop, 5'($urandom_range(0, 31))), ($urandom_range(0, 9) == 0));
        end

        for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(posedge CLK);
        if (sb_q.size() > 0) begin
            checks++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
